// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode side of the instruction fetch queue: push port, two-slot head view, pops, flush.
// Latency: pure wiring bundle, no state.
// Backpressure: push_ready gates acceptance of a fetch word; pops never stall.
//
// Signals:
//   push_valid/push_data/push_pc/push_ready : fetch word in (big-endian bit numbering, [0:31] = older)
//   out_valid0/out_inst0/out_pc0            : head instruction
//   out_valid1/out_inst1/out_pc1            : head+1 instruction
//   pop0/pop1                               : decode retires head / head+1
//   flush                                   : discard all contents
//   count                                   : current occupancy
interface inst_fetch_queue_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int INST_W     = 32,
  parameter int ADDR_W     = 64
);
  logic                  push_valid;
  logic [0:2*INST_W-1]   push_data;
  logic [ADDR_W-1:0]     push_pc;
  logic                  push_ready;
  logic                  out_valid0;
  logic [INST_W-1:0]     out_inst0;
  logic [ADDR_W-1:0]     out_pc0;
  logic                  out_valid1;
  logic [INST_W-1:0]     out_inst1;
  logic [ADDR_W-1:0]     out_pc1;
  logic                  pop0;
  logic                  pop1;
  logic                  flush;
  logic [DEPTH_LOG2:0]   count;

  // Queue side.
  modport slave (
    input  push_valid, push_data, push_pc, pop0, pop1, flush,
    output push_ready, out_valid0, out_inst0, out_pc0,
           out_valid1, out_inst1, out_pc1, count
  );

  // Fetch/decode side.
  modport master (
    output push_valid, push_data, push_pc, pop0, pop1, flush,
    input  push_ready, out_valid0, out_inst0, out_pc0,
           out_valid1, out_inst1, out_pc1, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular queue of instructions between fetch (one 2-instruction word per cycle) and dual-issue decode.
// Latency: a pushed pair is visible on the head outputs the cycle after the push edge; no bypass.
// Backpressure: push_ready = registered occupancy leaves room for a pair; refused pushes are dropped.
//
// Ports:
//   clk   : core clock, all state updates on rising edge
//   reset : synchronous active-high reset, priority over flush
//   q     : inst_fetch_queue_if.slave (push port, head/head+1 view, pops, flush, count)
module inst_fetch_queue #(
  parameter int DEPTH_LOG2 = 6,
  parameter int INST_W     = 32,
  parameter int ADDR_W     = 64
) (
  input  logic                clk,
  input  logic                reset,
  inst_fetch_queue_if.slave   q
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0]      FULL_THRESH = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0]      CNT_TWO     = CNT_W'(2);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_TWO     = DEPTH_LOG2'(2);
  localparam logic [ADDR_W-1:0]     PC_STEP     = ADDR_W'(4);

  logic [INST_W-1:0]     instMem [DEPTH];
  logic [ADDR_W-1:0]     pcMem   [DEPTH];

  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [CNT_W-1:0]      cnt;

  logic [DEPTH_LOG2-1:0] headPlus1;
  logic [DEPTH_LOG2-1:0] tailPlus1;
  logic                  pushReady;
  logic                  pushAcc;
  logic                  valid0;
  logic                  valid1;
  logic                  eff0;
  logic                  eff1;
  logic [1:0]            popCnt;

  // Pointer arithmetic wraps naturally in DEPTH_LOG2 bits.
  assign headPlus1 = head + PTR_ONE;
  assign tailPlus1 = tail + PTR_ONE;

  // Room for a full pair is judged on the registered count only, so a pop in
  // this cycle cannot open the door for a push in the same cycle.
  assign pushReady = (cnt <= FULL_THRESH);
  assign pushAcc   = q.push_valid & pushReady;

  assign valid0 = (cnt != '0);
  assign valid1 = (cnt > CNT_W'(1));

  // pop1 only counts alongside pop0, and pops beyond occupancy are silently dropped.
  assign eff0   = q.pop0 & valid0;
  assign eff1   = q.pop0 & q.pop1 & valid1;
  assign popCnt = {1'b0, eff0} + {1'b0, eff1};

  assign q.push_ready = pushReady;
  assign q.count      = cnt;
  assign q.out_valid0 = valid0;
  assign q.out_valid1 = valid1;
  assign q.out_inst0  = valid0 ? instMem[head]      : '0;
  assign q.out_pc0    = valid0 ? pcMem[head]        : '0;
  assign q.out_inst1  = valid1 ? instMem[headPlus1] : '0;
  assign q.out_pc1    = valid1 ? pcMem[headPlus1]   : '0;

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + DEPTH_LOG2'(popCnt);
      if (pushAcc) begin
        tail <= tail + PTR_TWO;
      end
      cnt <= cnt + (pushAcc ? CNT_TWO : '0) - CNT_W'(popCnt);
    end
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (pushAcc && !reset && !q.flush) begin
      instMem[tail]      <= q.push_data[0:INST_W-1];
      pcMem[tail]        <= q.push_pc;
      instMem[tailPlus1] <= q.push_data[INST_W:2*INST_W-1];
      pcMem[tailPlus1]   <= q.push_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  inst_fetch_queue_if #(.DEPTH_LOG2(6), .INST_W(32), .ADDR_W(64)) q ();

  inst_fetch_queue #(.DEPTH_LOG2(6), .INST_W(32), .ADDR_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q.push_valid = 1'b0;
    q.push_data  = '0;
    q.push_pc    = '0;
    q.pop0       = 1'b0;
    q.pop1       = 1'b0;
    q.flush      = 1'b0;
  endtask

  task automatic setPush(input logic [31:0] older, input logic [31:0] younger, input logic [63:0] pc);
    q.push_valid = 1'b1;
    q.push_data  = {older, younger};
    q.push_pc    = pc;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count",  64'(q.count), 64'd0);
    chk("rst_valid0", 64'(q.out_valid0), 64'd0);
    chk("rst_valid1", 64'(q.out_valid1), 64'd0);
    chk("rst_ready",  64'(q.push_ready), 64'd1);
    chk("rst_inst0",  64'(q.out_inst0), 64'd0);

    // First pair: older instruction is the upper hex half
    setPush(32'h7C221A14, 32'h38600005, 64'h100);
    tick();
    idle();
    chk("p1_inst0",  64'(q.out_inst0), 64'h7C221A14);
    chk("p1_pc0",    q.out_pc0, 64'h100);
    chk("p1_inst1",  64'(q.out_inst1), 64'h38600005);
    chk("p1_pc1",    q.out_pc1, 64'h104);
    chk("p1_count",  64'(q.count), 64'd2);
    chk("p1_valid1", 64'(q.out_valid1), 64'd1);

    // Single pop leaves the younger half at head
    q.pop0 = 1'b1;
    tick();
    idle();
    chk("pop0_inst0",  64'(q.out_inst0), 64'h38600005);
    chk("pop0_pc0",    q.out_pc0, 64'h104);
    chk("pop0_valid1", 64'(q.out_valid1), 64'd0);
    chk("pop0_count",  64'(q.count), 64'd1);

    // Dual pop with only one valid: pop1 ignored
    q.pop0 = 1'b1;
    q.pop1 = 1'b1;
    tick();
    idle();
    chk("pop2_count",  64'(q.count), 64'd0);
    chk("pop2_valid0", 64'(q.out_valid0), 64'd0);
    chk("pop2_valid1", 64'(q.out_valid1), 64'd0);

    // Pop on empty is a no-op
    q.pop0 = 1'b1;
    q.pop1 = 1'b1;
    tick();
    idle();
    chk("empty_pop_count", 64'(q.count), 64'd0);

    // Fill to 64 entries
    for (int i = 0; i < 32; i++) begin
      setPush(32'hA000_0000 + 32'(2*i), 32'hA000_0000 + 32'(2*i+1), 64'h1000 + 64'(8*i));
      tick();
    end
    idle();
    chk("full_count", 64'(q.count), 64'd64);
    chk("full_ready", 64'(q.push_ready), 64'd0);
    chk("full_valid1", 64'(q.out_valid1), 64'd1);

    // 33rd push is dropped
    setPush(32'hFFFF_FFFF, 32'hEEEE_EEEE, 64'hF000);
    tick();
    idle();
    chk("over_count", 64'(q.count), 64'd64);
    chk("over_inst0", 64'(q.out_inst0), 64'hA000_0000);
    chk("over_inst1", 64'(q.out_inst1), 64'hA000_0001);

    q.pop0 = 1'b1;
    tick();
    idle();
    chk("p63_count", 64'(q.count), 64'd63);
    chk("p63_ready", 64'(q.push_ready), 64'd0);
    chk("p63_inst0", 64'(q.out_inst0), 64'hA000_0001);

    q.pop0 = 1'b1;
    tick();
    idle();
    chk("p62_count", 64'(q.count), 64'd62);
    chk("p62_ready", 64'(q.push_ready), 64'd1);
    chk("p62_inst0", 64'(q.out_inst0), 64'hA000_0002);
    chk("p62_pc0",   q.out_pc0, 64'h1008);

    // Drain
    for (int i = 0; i < 31; i++) begin
      q.pop0 = 1'b1;
      q.pop1 = 1'b1;
      tick();
    end
    idle();
    chk("drain_count", 64'(q.count), 64'd0);

    // Steady push + dual pop across pointer wrap
    for (int k = 0; k < 100; k++) begin
      setPush(32'hB000_0000 + 32'(2*k), 32'hB000_0000 + 32'(2*k+1), 64'h8000 + 64'(8*k));
      q.pop0 = 1'b1;
      q.pop1 = 1'b1;
      tick();
      chk("steady_count", 64'(q.count), 64'd2);
      chk("steady_pc0",   q.out_pc0, 64'h8000 + 64'(8*k));
      chk("steady_pc1",   q.out_pc1, 64'h8004 + 64'(8*k));
      chk("steady_inst0", 64'(q.out_inst0), 64'hB000_0000 + 64'(2*k));
    end
    idle();

    // Build count=10, then flush with push and pops in the same cycle
    for (int i = 0; i < 4; i++) begin
      setPush(32'h9000_0000 + 32'(2*i), 32'h9000_0000 + 32'(2*i+1), 64'h9000 + 64'(8*i));
      tick();
    end
    idle();
    chk("pre_flush_count", 64'(q.count), 64'd10);
    setPush(32'hDEAD_BEEF, 32'hCAFE_F00D, 64'hDEAD0);
    q.pop0  = 1'b1;
    q.pop1  = 1'b1;
    q.flush = 1'b1;
    tick();
    idle();
    chk("flush_count",  64'(q.count), 64'd0);
    chk("flush_valid0", 64'(q.out_valid0), 64'd0);
    chk("flush_valid1", 64'(q.out_valid1), 64'd0);
    tick();
    chk("flush_absent", 64'(q.count), 64'd0);

    // Odd head alignment: head+1 wraps from index 63 to 0
    for (int i = 0; i < 32; i++) begin
      setPush(32'hC000_0000 + 32'(2*i), 32'hC000_0000 + 32'(2*i+1), 64'hC000 + 64'(8*i));
      tick();
    end
    idle();
    q.pop0 = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) begin
      q.pop0 = 1'b1;
      q.pop1 = 1'b1;
      tick();
    end
    idle();
    chk("odd_count3", 64'(q.count), 64'd3);
    setPush(32'hD000_0000, 32'hD000_0001, 64'hD000);
    tick();
    idle();
    chk("odd_count5", 64'(q.count), 64'd5);
    q.pop0 = 1'b1;
    q.pop1 = 1'b1;
    tick();
    idle();
    chk("wrap_inst0", 64'(q.out_inst0), 64'hC000_003F);
    chk("wrap_pc0",   q.out_pc0, 64'hC0FC);
    chk("wrap_inst1", 64'(q.out_inst1), 64'hD000_0000);
    chk("wrap_pc1",   q.out_pc1, 64'hD000);

    // Reach count=20, then reset during pops and push
    q.pop0 = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 9; i++) begin
      setPush(32'h5000_0000 + 32'(2*i), 32'h5000_0000 + 32'(2*i+1), 64'h5000 + 64'(8*i));
      tick();
    end
    idle();
    chk("pre_rst_count", 64'(q.count), 64'd20);
    setPush(32'h1111_1111, 32'h2222_2222, 64'h1110);
    q.pop0 = 1'b1;
    q.pop1 = 1'b1;
    q.flush = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rst2_count",  64'(q.count), 64'd0);
    chk("rst2_ready",  64'(q.push_ready), 64'd1);
    chk("rst2_valid0", 64'(q.out_valid0), 64'd0);

    // pop1 without pop0 leaves state alone
    setPush(32'hE000_0000, 32'hE000_0001, 64'hE000);
    tick();
    idle();
    q.pop1 = 1'b1;
    tick();
    idle();
    chk("pop1only_count", 64'(q.count), 64'd2);
    chk("pop1only_pc0",   q.out_pc0, 64'hE000);
    chk("pop1only_inst1", 64'(q.out_inst1), 64'hE000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Buffers instruction pairs between fetch and dual-issue decode.
- Each cycle, fetch pushes one 64-bit memory word, which holds two 32-bit instructions, together with the word's PC.
- Decode sees the two oldest instructions and their PCs, and retires 0, 1 or 2 of them per cycle.
- Replaces the ad-hoc head/tail queue in the core top level. Adds backpressure to fetch and a flush path for redirects.

Parameters:
DEPTH_LOG2, 6, log2 of entry count (64 instruction slots); must be >= 2
INST_W, 32, instruction width
ADDR_W, 64, PC width

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
push_valid  input  1  fetch presents a word this cycle
push_data  input  2*INST_W  fetched word; bits [0:31] = older instruction, [32:63] = younger
push_pc  input  ADDR_W  PC of push_data[0:31]; younger instruction PC = push_pc+4
push_ready  output  1  queue can accept a pair (free slots >= 2)
out_valid0  output  1  slot at head holds an instruction
out_inst0  output  INST_W  instruction at head
out_pc0  output  ADDR_W  PC of head instruction
out_valid1  output  1  slot at head+1 holds an instruction
out_inst1  output  INST_W  instruction at head+1
out_pc1  output  ADDR_W  PC of head+1 instruction
pop0  input  1  decode consumes head instruction
pop1  input  1  decode also consumes head+1 instruction (meaningful only with pop0)
flush  input  1  discard all contents (branch/sc redirect)
count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2

Behaviour:
- State:
  - inst array and pc array, 2^DEPTH_LOG2 entries each.
  - head and tail pointers, DEPTH_LOG2 bits, wrap modulo 2^DEPTH_LOG2.
  - count register.
- Reset (sync): head=tail=count=0, so all valid outputs read 0 and push_ready=1. Array contents are don't-care. Reset overrides every other input.
- push_ready = (count <= 2^DEPTH_LOG2 - 2).
  - Computed from the registered count only; same-cycle pops do not raise it.
- Push accepted = push_valid & push_ready. On acceptance:
  - entry[tail] <= push_data[0:31], pc[tail] <= push_pc.
  - entry[tail+1] <= push_data[32:63], pc[tail+1] <= push_pc+4, with modulo-64 arithmetic.
  - tail <= tail+2, wrapping.
- Push while push_ready=0: dropped, no state change. Fetch must hold the word.
- Outputs are read combinationally from head and head+1 (wrapping).
  - out_valid0 = (count>=1); out_valid1 = (count>=2).
  - Invalid outputs drive zero.
- Latency: a pushed pair becomes visible on the outputs on the cycle after the push edge. There is no bypass.
- Effective pops:
  - e0 = pop0 & out_valid0.
  - e1 = pop0 & pop1 & out_valid1.
  - pop1 without pop0 is ignored. Pops beyond occupancy are ignored; this is not an error.
  - head <= head + e0 + e1.
- count <= count + 2*accepted - e0 - e1, so simultaneous push and pop are net-accounted in one cycle.
- Odd occupancy is legal: a single pop leaves the younger half of a pair at head.
- Full (count=64): push_ready=0, both outputs valid.
- Empty: no outputs valid, pops are no-ops.
- flush (sync): head=tail=count=0 next cycle.
  - Overrides push and pops in the same cycle; a same-cycle push is discarded.
  - reset has priority over flush.

Test Plan:
- Reset, then push_data=0x7C221A14_38600005, push_pc=0x100, no pops -> next cycle out_inst0=0x7C221A14/pc 0x100, out_inst1=0x38600005/pc 0x104, count=2.
- From that state, pop0 only -> out_inst0=0x38600005, pc 0x104, out_valid1=0, count=1. Then pop0+pop1 -> count=0, both valids 0, pop1 ignored.
- 32 pushes with no pops -> count=64, push_ready=0. A 33rd push leaves head data unchanged. Pop 1 -> count=63, push_ready still 0. Pop another 1 -> push_ready=1.
- Steady push plus dual pop for 100 cycles -> count constant at 2 and PCs increment by 8 per cycle across pointer wrap. Verify the entry at index 63 is followed by index 0.
- With count=10, assert flush, push_valid and pop0+pop1 in the same cycle -> next cycle count=0, outputs invalid, the pushed pair is absent.
- Assert reset while count=20 and pops are active -> next cycle count=0 and push_ready=1. pop1 alone on a non-empty queue -> no state change.
